// File: rtl/treintaydos_bit_ocho_bit_pkg.sv
// rtl/treintaydos_bit_ocho_bit_pkg.sv - shared widths and types for the word/byte converters
// Purpose: constants and types common to the 32b->8b serializer and the 8b->32b packer.
// Ports: none (package).
package treintaydos_bit_ocho_bit_pkg;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  // Index of a byte within a word, 0..3.
  typedef logic [1:0] byte_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/treintaydos_bit_ocho_bit_word_hold_reg.sv
// rtl/treintaydos_bit_ocho_bit_word_hold_reg.sv - one-entry word holding register
// Purpose: parks one early word while the output stage is still sending.
// Ports:
//   clk_4f   in   byte-rate clock
//   reset_L  in   asynchronous active-low reset
//   load     in   capture data_in (wins over consume, so a same-edge refill keeps hold_v=1)
//   consume  in   the output stage took the held word
//   data_in  in   word to capture
//   word     out  held word
//   hold_v   out  word register is occupied
//   ready    out  register can accept a word (!hold_v)
module word_hold_reg
  import treintaydos_bit_ocho_bit_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic              load,
  input  logic              consume,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] word,
  output logic              hold_v,
  output logic              ready
);

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      word   <= '0;
      hold_v <= 1'b0;
    end else if (load) begin
      word   <= data_in;
      hold_v <= 1'b1;
    end else if (consume) begin
      hold_v <= 1'b0;
    end
  end

  assign ready = !hold_v;

endmodule

// File: rtl/treintaydos_bit_ocho_bit.sv
// rtl/treintaydos_bit_ocho_bit.sv - 32-bit word to 8-bit byte serializer, MSB byte first
// Purpose: accepts words on a valid/ready handshake and emits each as four contiguous bytes.
// Ports:
//   clk_4f        in   byte-rate clock
//   reset_L       in   asynchronous active-low reset
//   data_in       in   input word
//   valid_in      in   data_in valid this cycle
//   ready_out     out  a word can be accepted this cycle (!hold_v, no path from valid_in)
//   data_out      out  output byte, 8'h00 when valid_out=0
//   valid_out     out  data_out carries a byte
//   overflow_err  out  sticky: a word was offered while ready_out=0 and dropped
module treintaydos_bit_ocho_bit
  import treintaydos_bit_ocho_bit_pkg::*;
(
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        overflow_err
);

  localparam int        REM_W      = WORD_W - BYTE_W;
  localparam byte_idx_t LAST_COUNT = byte_idx_t'(BYTES_PER_WORD - 1);

  state_t              state_q, state_d;
  logic [REM_W-1:0]    cur_q, cur_d;
  byte_idx_t           left_q, left_d;
  logic [BYTE_W-1:0]   data_d;
  logic                valid_d;

  logic [WORD_W-1:0]   hold_word;
  logic                hold_v;
  logic                hold_ready;
  logic                accept;
  logic                load;
  logic                consume;

  assign accept    = valid_in && hold_ready;
  assign ready_out = hold_ready;

  word_hold_reg u_hold (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .load    (load),
    .consume (consume),
    .data_in (data_in),
    .word    (hold_word),
    .hold_v  (hold_v),
    .ready   (hold_ready)
  );

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      left_q    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      left_q    <= left_d;
      data_out  <= data_d;
      valid_out <= valid_d;
    end
  end

  // Output stage priority: finish the current word, then the held word,
  // then bypass a fresh word straight out. Any accept that the bypass
  // does not take lands in the holding register.
  always_comb begin
    state_d = IDLE;
    cur_d   = cur_q;
    left_d  = left_q;
    data_d  = '0;
    valid_d = 1'b0;
    load    = 1'b0;
    consume = 1'b0;
    if (state_q == SEND && left_q != '0) begin
      data_d  = cur_q[REM_W-1 -: BYTE_W];
      cur_d   = {cur_q[REM_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      left_d  = left_q - byte_idx_t'(1);
      valid_d = 1'b1;
      state_d = SEND;
      load    = accept;
    end else if (hold_v) begin
      data_d  = hold_word[WORD_W-1 -: BYTE_W];
      cur_d   = hold_word[REM_W-1:0];
      left_d  = LAST_COUNT;
      valid_d = 1'b1;
      state_d = SEND;
      consume = 1'b1;
      load    = accept;
    end else if (accept) begin
      data_d  = data_in[WORD_W-1 -: BYTE_W];
      cur_d   = data_in[REM_W-1:0];
      left_d  = LAST_COUNT;
      valid_d = 1'b1;
      state_d = SEND;
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      overflow_err <= 1'b0;
    end else if (valid_in && !hold_ready) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: doc/treintaydos_bit_ocho_bit.md
# treintaydos_bit_ocho_bit

Word-to-byte serializer: accepts 32-bit words with a valid/ready handshake and emits them as four consecutive 8-bit bytes, MSB byte first. It is the transmit-side counterpart of the 8b→32b packer. Its byte stream (data_out/valid_out, four contiguous valid bytes per word) is the format the packer reassembles. A one-word holding register absorbs upstream jitter so that words arriving at most once every 4 cycles stream with no bubbles.

## Interface
- No parameters. Widths are fixed: 32-bit input, 8-bit output, 4 bytes per word.

- clk_4f  in  1  byte-rate clock, rising-edge; single clock domain
- reset_L  in  1  asynchronous, active-low reset
- data_in  in  32  input word
- valid_in  in  1  data_in valid this cycle
- ready_out  out  1  block can accept a word this cycle; equals !hold_v (no combinational path from valid_in)
- data_out  out  8  output byte; 8'h00 whenever valid_out=0
- valid_out  out  1  data_out carries a byte
- overflow_err  out  1  sticky: a word was offered while ready_out=0 and was dropped

## Operation
- Accept: a word is taken on a clk_4f edge where valid_in=1 && ready_out=1.
- Internal state:
  - cur: 24-bit remainder of the word being sent.
  - bytes_left: 0..3.
  - hold: 32-bit word register, with hold_v.
- Per-edge priority for the output stage:
  1. bytes_left>0: data_out<=cur[23:16]; cur<=cur<<8; bytes_left--; valid_out<=1.
  2. else hold_v: data_out<=hold[31:24]; cur<=hold[23:0]; bytes_left<=3; valid_out<=1; hold_v<=0.
  3. else accept: bypass. data_out<=data_in[31:24]; cur<=data_in[23:0]; bytes_left<=3; valid_out<=1.
  4. else idle: valid_out<=0; data_out<=8'h00.
- Accept not consumed by bypass: hold<=data_in; hold_v<=1. An accept in the same edge that case 2 empties hold refills it, so hold_v stays 1.
- States:
  - IDLE: bytes_left=0, valid_out=0.
  - SEND: byte index 0..3.
  - IDLE→SEND on accept or hold_v. SEND→SEND (next word) when the last byte is out and hold_v or accept. Otherwise SEND→IDLE.
- The four bytes of a word are always emitted on four consecutive cycles and are never interleaved or gapped.
- Overflow: valid_in=1 while ready_out=0 drops the word and sets overflow_err=1. It clears only on reset. The in-flight word and held word are unaffected.

## Timing
- Reset values: data_out=8'h00, valid_out=0, overflow_err=0, ready_out=1, bytes_left=0, hold_v=0.
- Latency: word accepted at edge N (IDLE, hold empty) → byte[31:24] valid after edge N, then bytes [23:16], [15:8], [7:0] after edges N+1..N+3.
- Throughput: 1 word per 4 cycles sustained. A word arriving exactly 4 cycles after the previous accept bypasses with no gap.
- A word arriving early (1–3 cycles after the previous accept) goes to hold. ready_out=0 from the next cycle until the edge hold is consumed.
- Reset asserted mid-word: outputs go to reset values immediately (async). The partial word and held word are discarded. Nothing resumes after reset_L rises.
- Reset is deasserted externally synchronous to clk_4f.

## Structure
- Shared package (common with the packer):
  - BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4.
  - 2-bit byte-index type.
- Natural sub-module: word_hold_reg (1-entry 32-bit register with load/consume and hold_v, exposing ready). The remainder stays in the top level.

## Test plan
- Reset: hold reset_L=0 with valid_in toggling → data_out=00, valid_out=0, ready_out=1, overflow_err=0 throughout.
- Single word 32'hA1B2C3D4 accepted at edge 0 → after edges 0..3 data_out=A1,B2,C3,D4 with valid_out=1; after edge 4 valid_out=0, data_out=00.
- Words 32'h01020304 and 32'h05060708 offered at edges 0 and 4 → eight contiguous valid bytes 01..08; ready_out stays 1.
- Words 32'h11223344 at edge 0 and 32'h55667788 at edge 1 → ready_out=0 during cycles 2–4; bytes 11,22,33,44,55,66,77,88 contiguous after edges 0..7.
- Words at edges 0, 1, 2 (third 32'hDEADBEEF while ready_out=0) → DEADBEEF bytes never appear; overflow_err=1 from after edge 2 and stays 1; first two words stream intact.
- Word 32'hCAFEF00D accepted, reset_L pulsed low after two bytes (CA, FE) → valid_out=0 immediately; F0/0D never emitted; next word after reset streams normally from its MSB byte.
